// File: rtl/mul_inv_div_seq.sv
// Sequential restoring divider that inverts the approximate multipliers.
// It takes a 2*WIDTH-bit product word and one known WIDTH-bit factor. It
// recovers the other factor and a remainder. A nonzero remainder, or a
// quotient the caller did not expect, shows that the product was approximated.
//
// Handshake: valid/ready on both sides, with one operation in flight at a time.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | in_ready=1, waiting for in_valid; result registers keep last value
// BUSY  | one restoring shift/subtract step per cycle, N steps in total
// DONE  | out_valid=1, result held until out_ready is seen at an edge
module mul_inv_div_seq #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               exact,
  output logic               dbz
);

  localparam int N  = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  // After every step the partial remainder is below the divisor, so WIDTH
  // bits are enough to hold it. Only the trial value needs the extra bit.
  logic [WIDTH-1:0] r;
  logic [N-1:0]     q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH:0]   r_next;
  logic [N-1:0]     q_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then subtract the divisor when the result fits.
  always_comb begin
    t      = {r, q[N-1]};
    ge     = (t >= {1'b0, dvs});
    r_next = ge ? (t - {1'b0, dvs}) : t;
    q_next = {q[N-2:0], ge};
  end

  // Handshake outputs decode the registered state only. This keeps any
  // input-to-output path from being combinational.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // FSM, iteration registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs <= divisor;
            if (divisor == '0) begin
              // Divide by zero skips the iteration and reports a saturated quotient.
              quotient  <= '1;
              remainder <= '0;
              exact     <= 1'b0;
              dbz       <= 1'b1;
              state     <= DONE;
            end else begin
              r     <= '0;
              q     <= dividend;
              cnt   <= CW'(N - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          r   <= r_next[WIDTH-1:0];
          q   <= q_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            exact     <= (r_next == '0);
            dbz       <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_inv_div_seq.sv
// Directed bench for mul_inv_div_seq at WIDTH=2. All expected values are
// worked out by hand or from plain integer division in the bench.
module tb_mul_inv_div_seq;

  localparam int WIDTH = 2;
  localparam int N     = 2 * WIDTH;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       exact;
  logic       dbz;

  int n_vec;
  int n_bad;

  mul_inv_div_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .exact     (exact),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait one rising edge, then step clear of it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present one operation for a single accept edge, then
  // count the edges after the accept edge until out_valid is observed high.
  // lat = 0 means out_valid is already high in the cycle right after accept.
  task automatic run_op(input logic [3:0] dd, input logic [1:0] ds, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL run_op_ready_timeout: in_ready=%b required 1", in_ready);
    end
    dividend = dd;
    divisor  = ds;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [3:0] dd, input logic [1:0] ds,
                          input logic [3:0] eq, input logic [1:0] er, input logic ee,
                          input logic ez, input int elat);
    int lat;
    run_op(dd, ds, lat);
    n_vec++;
    if (lat != elat) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, elat);
    end
    n_vec++;
    if ({quotient, remainder, exact, dbz} !== {eq, er, ee, ez}) begin
      n_bad++;
      $display("FAIL %s_result: got q=%0d r=%0d exact=%b dbz=%b required q=%0d r=%0d exact=%b dbz=%b",
               name, quotient, remainder, exact, dbz, eq, er, ee, ez);
    end
    release_result();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL %s_release: got out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_vec++;
    if ({in_ready, out_valid, quotient, remainder, exact, dbz} !== {1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b q=%0d r=%0d exact=%b dbz=%b required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, exact, dbz);
    end
  endtask

  task automatic test_directed();
    check_op("div_9_3",  4'd9,  2'd3, 4'd3,  2'd0, 1'b1, 1'b0, N);
    check_op("div_7_2",  4'd7,  2'd2, 4'd3,  2'd1, 1'b0, 1'b0, N);
    check_op("div_15_1", 4'd15, 2'd1, 4'd15, 2'd0, 1'b1, 1'b0, N);
    check_op("div_0_3",  4'd0,  2'd3, 4'd0,  2'd0, 1'b1, 1'b0, N);
    check_op("div_6_0",  4'd6,  2'd0, 4'd15, 2'd0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(4'd9, 2'd3, lat);
    n_vec++;
    if (lat != N) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d required %0d", lat, N);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        dividend = 4'd5;
        divisor  = 2'd1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n_vec++;
      if ({out_valid, in_ready, quotient, remainder, exact, dbz} !== {1'b1, 1'b0, 4'd3, 2'd0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b q=%0d r=%0d exact=%b dbz=%b required 1 0 3 0 1 0",
                 i, out_valid, in_ready, quotient, remainder, exact, dbz);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_vec++;
    if ({out_valid, in_ready, quotient} !== {1'b0, 1'b1, 4'd3}) begin
      n_bad++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b q=%0d required 0 1 3", out_valid, in_ready, quotient);
    end
    // The pulse that arrived while DONE must not have started an operation.
    for (int i = 0; i < N + 2; i++) tick();
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_ignored_pulse: got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    dividend = 4'd9;
    divisor  = 2'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if ({in_ready, out_valid, quotient, remainder, exact, dbz} !== {1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got in_ready=%b out_valid=%b q=%0d r=%0d exact=%b dbz=%b required 1 0 0 0 0 0",
               in_ready, out_valid, quotient, remainder, exact, dbz);
    end
    rst_n = 1'b1;
    check_op("after_reset_4_2", 4'd4, 2'd2, 4'd2, 2'd0, 1'b1, 1'b0, N);
  endtask

  // With in_valid and out_ready held high, accepts land N+2 edges apart.
  // out_valid should then be seen only after edges N and 2N+2 of the window.
  task automatic test_back_to_back();
    int hits [$];
    dividend  = 4'd7;
    divisor   = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int k = 1; k <= 2 * N + 3; k++) begin
      tick();
      if (out_valid) hits.push_back(k);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (hits.size() != 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d out_valid cycles required 2", hits.size());
    end else begin
      n_vec++;
      if (hits[0] != N || hits[1] != 2 * N + 2) begin
        n_bad++;
        $display("FAIL b2b_spacing: got %0d,%0d required %0d,%0d", hits[0], hits[1], N, 2 * N + 2);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_sweep();
    logic [3:0] eq;
    logic [1:0] er;
    logic       ee;
    logic       ez;
    int         elat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 0) begin
          eq = 4'd15; er = 2'd0; ee = 1'b0; ez = 1'b1; elat = 0;
        end else begin
          eq = 4'(a / b); er = 2'(a % b); ee = ((a % b) == 0); ez = 1'b0; elat = N;
        end
        check_op($sformatf("sweep_%0d_%0d", a, b), 4'(a), 2'(b), eq, er, ee, ez, elat);
      end
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
